mips_hazard_ctrl: RTL and testbench

Hazard controller that generates the `stall` and `flush` inputs consumed by `mips_pipeline_top`.
- Monitors the instruction in ID and a shadow tracker of the instructions in EX and MEM.
- Detects load-use hazards, multiply/divide busy hazards and taken branches.
- Forwarding (EX/MEM, MEM/WB) exists in the datapath, so only a load followed by a dependent use costs a bubble.
- Keeps saturating statistics counters for stalls and flushes.

---
 rtl/mips_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_mips_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_ctrl.sv
// Hazard controller: derives pipeline stall/flush from ID operands, an EX/MEM
// shadow tracker and the mult/div busy timer; keeps saturating statistics.
module mips_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       hazard_state,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } trk_t;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_STALL  = 2'd1,
        MULDIV_WAIT = 2'd2,
        FLUSH       = 2'd3
    } hz_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    trk_t       ex_q, mem_q;
    logic [3:0] busy_q;
    logic       load_use, muldiv_haz, issue;
    hz_t        hz;

    assign muldiv_busy = (busy_q != 4'd0);

    // Only EX loads matter: a load already in MEM is covered by MEM/WB forwarding.
    always_comb begin
        load_use = id_valid & ex_q.valid & ex_q.mem_read & ex_q.reg_write &
                   (ex_q.dest != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_q.dest)) |
                    (id_uses_rt & (id_rt == ex_q.dest)));
        muldiv_haz = id_valid & muldiv_busy & (id_is_muldiv | id_reads_hilo);
    end

    // While reset is held the hazard outputs are forced quiet; only mem_wait passes.
    always_comb begin
        flush = ex_branch_taken & ~mem_wait & ~reset;
        stall = mem_wait | (~flush & ~reset & (load_use | muldiv_haz));
        issue = id_valid & ~stall & ~flush;
        hz    = RUN;
        if (reset)           hz = RUN;
        else if (flush)      hz = FLUSH;
        else if (load_use)   hz = LOAD_STALL;
        else if (muldiv_haz) hz = MULDIV_WAIT;
    end

    assign hazard_state = hz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!mem_wait) begin
            mem_q <= ex_q;
            ex_q  <= '{valid: issue, dest: id_dest,
                       reg_write: id_reg_write, mem_read: id_mem_read};
        end
    end

    // The mult/div unit runs on its own, so the timer keeps counting through mem_wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_q <= 4'd0;
        else if (issue && id_is_muldiv)
            busy_q <= 4'(MULDIV_LAT);
        else if (busy_q != 4'd0)
            busy_q <= busy_q - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_ONE;
            if (flush && flush_events != '1) flush_events <= flush_events + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Randomized + directed bench for mips_hazard_ctrl against a queue-based
// model of the in-flight instructions and the mult/div timer.
module tb_mips_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0, reset = 1'b1;
    logic             id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic             id_is_muldiv, id_reads_hilo, ex_branch_taken, mem_wait;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic             stall, flush, muldiv_busy;
    logic [1:0]       hazard_state;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    mips_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .stall(stall), .flush(flush), .hazard_state(hazard_state),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    typedef struct {
        bit v; int rs, rt; bit urs, urt; int dest; bit rw, mr, md, hilo;
    } ins_t;

    typedef struct { bit v; int dest; bit rw, mr; } fly_t;

    int   total = 0, bad = 0;
    fly_t pipe[$];          // [0] = instruction in EX, [1] = in MEM
    int   busy_left, m_stalls, m_flushes;
    bit   e_stall, e_flush;
    int   e_state;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest,
                                bit rw, bit mr, bit md, bit hilo);
        mk = '{v, rs, rt, urs, urt, dest, rw, mr, md, hilo};
    endfunction

    function automatic ins_t nop();
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        fly_t z = '{0, 0, 0, 0};
        pipe = {z, z};
        busy_left = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic drive(input ins_t i, input bit br, input bit mw);
        id_valid = i.v; id_rs = 5'(i.rs); id_rt = 5'(i.rt);
        id_uses_rs = i.urs; id_uses_rt = i.urt; id_dest = 5'(i.dest);
        id_reg_write = i.rw; id_mem_read = i.mr;
        id_is_muldiv = i.md; id_reads_hilo = i.hilo;
        ex_branch_taken = br; mem_wait = mw;
    endtask

    // One cycle: drive at negedge, compare mid-cycle, then advance the model
    // to match what the DUT commits at the following rising edge.
    task automatic cyc(input ins_t i, input bit br, input bit mw);
        bit ld, mdh, iss;
        fly_t e;
        @(negedge clk);
        drive(i, br, mw);
        #2;
        e = pipe[0];
        ld  = i.v && e.v && e.mr && e.rw && e.dest != 0 &&
              ((i.urs && i.rs == e.dest) || (i.urt && i.rt == e.dest));
        mdh = i.v && busy_left > 0 && (i.md || i.hilo);
        e_flush = br && !mw;
        e_stall = mw || (!e_flush && (ld || mdh));
        e_state = e_flush ? 3 : ld ? 1 : mdh ? 2 : 0;
        chk("stall", stall, e_stall);
        chk("flush", flush, e_flush);
        chk("state", hazard_state, e_state);
        chk("busy", muldiv_busy, busy_left > 0);
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("flush_events", flush_events, m_flushes);
        iss = i.v && !e_stall && !e_flush;
        if (!mw) begin
            void'(pipe.pop_back());
            pipe.push_front('{iss, i.dest, i.rw, i.mr});
        end
        if (iss && i.md) busy_left = LAT;
        else if (busy_left > 0) busy_left--;
        if (e_stall) m_stalls = (m_stalls + 1 > SAT) ? SAT : m_stalls + 1;
        if (e_flush) m_flushes = (m_flushes + 1 > SAT) ? SAT : m_flushes + 1;
    endtask

    initial begin
        ins_t lw4, add4, lw0, rd0, addu, mult, mflo;
        int   n;
        lw4  = mk(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
        add4 = mk(1, 4, 2, 1, 1, 5, 1, 0, 0, 0);
        lw0  = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
        rd0  = mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
        addu = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        mult = mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
        mflo = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
        drive(nop(), 0, 0);
        model_reset();
        #12 reset = 1'b0;

        // Load-use: exactly one bubble, then the dependent add issues
        cyc(lw4, 0, 0);
        cyc(add4, 0, 0);
        chk("lu_stall", stall, 1);
        chk("lu_state", hazard_state, 1);
        cyc(add4, 0, 0);
        chk("lu_issue", stall, 0);
        cyc(nop(), 0, 0);
        chk("lu_count", stall_cycles, 1);

        // $0 destination and unrelated operands never stall
        cyc(lw0, 0, 0);
        cyc(rd0, 0, 0);
        chk("r0_nostall", stall, 0);
        cyc(lw4, 0, 0);
        cyc(addu, 0, 0);
        chk("unrel_nostall", stall, 0);

        // Mult followed by mflo waits LAT cycles in MULDIV_WAIT
        cyc(mult, 0, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(mflo, 0, 0);
            if (!e_stall) break;
            chk("md_state", hazard_state, 2);
            n++;
        end
        chk("md_stall_len", n, LAT);
        cyc(mult, 0, 0);
        cyc(addu, 0, 0);
        chk("md_add_nostall", stall, 0);
        for (int k = 0; k < LAT; k++) cyc(nop(), 0, 0);

        // Branch beats load-use; during mem_wait the flush is deferred
        cyc(lw4, 0, 0);
        cyc(add4, 1, 0);
        chk("br_flush", flush, 1);
        chk("br_nostall", stall, 0);
        cyc(lw4, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(add4, 1, 1);
            chk("mw_noflush", flush, 0);
        end
        cyc(add4, 1, 0);
        chk("mw_flush_after", flush, 1);

        // Long mem_wait saturates stall_cycles while the mult timer drains
        cyc(mult, 0, 0);
        for (int k = 0; k < 20; k++) cyc(nop(), 0, 1);
        chk("sat_stall", stall_cycles, SAT);
        chk("sat_busy_drained", muldiv_busy, 0);

        // Async reset in the middle of a load-use stall
        cyc(lw4, 0, 0);
        cyc(add4, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_state", hazard_state, 0);
        chk("rst_sc", stall_cycles, 0);
        chk("rst_fe", flush_events, 0);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;

        // Random traffic over a small register set to make hazards frequent
        for (int k = 0; k < 1500; k++) begin
            ins_t r;
            r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            cyc(r, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
